// File: rtl/md_issue_ctrl_pkg.sv
// md_issue_ctrl_pkg
// Shared definitions for the multiply/divide issue sequencer: opcode fields,
// ALU op codes for mul/div, the rstatus register index and codes, the
// sequencer state type, and small decode/encode helpers.
package md_issue_ctrl_pkg;

    localparam logic [4:0] OPC_RTYPE   = 5'b00000;
    localparam logic [4:0] OPC_ADDI    = 5'b00101;
    localparam logic [4:0] ALU_MUL     = 5'b00110;
    localparam logic [4:0] ALU_DIV     = 5'b00111;
    localparam logic [4:0] RSTATUS_REG = 5'd30;

    localparam int unsigned RSTATUS_MUL_CODE = 4;
    localparam int unsigned RSTATUS_DIV_CODE = 5;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StBusy,
        StDone
    } md_state_e;

    // True for an R-type mul or div; the all-zero word (nop) is excluded.
    function automatic logic is_md_op(logic [31:0] ir);
        return (ir[31:27] == OPC_RTYPE) && (ir != 32'd0) &&
               ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
    endfunction

    // addi $r30, $r0, code -- the synthesized exception write.
    function automatic logic [31:0] rstatus_ir(logic [16:0] code);
        return {OPC_ADDI, RSTATUS_REG, 5'd0, code};
    endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if
// Bundles the X-stage inputs, the mul/div unit handshake and the X/M override
// outputs of md_issue_ctrl.
//   master : the sequencer (drives unit start/operands, stall, override)
//   slave  : the pipeline + unit side (drives instruction, operands, unit result)
interface md_issue_ctrl_if;

    logic [31:0] ir_x;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;

    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_value;

    modport master (
        input  ir_x, operand_a, operand_b, md_result, md_exception, md_ready,
        output md_ctrl_mult, md_ctrl_div, md_a, md_b, stall, busy,
               out_valid, out_ir, out_value
    );

    modport slave (
        output ir_x, operand_a, operand_b, md_result, md_exception, md_ready,
        input  md_ctrl_mult, md_ctrl_div, md_a, md_b, stall, busy,
               out_valid, out_ir, out_value
    );

endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl
// Shares one iterative mul/div unit with the pipeline. A mul/div seen in X
// while idle is captured, the unit is started with a one-cycle pulse, and the
// pipeline front is stalled until the unit is ready or the wait times out.
// One cycle of X/M override follows: the instruction with the unit result, or
// an addi $r30 status write on exception/timeout.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : md_issue_ctrl_if.master (X-stage inputs, unit handshake, override)
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 40,
    parameter int unsigned RSTATUS_MUL = RSTATUS_MUL_CODE,
    parameter int unsigned RSTATUS_DIV = RSTATUS_DIV_CODE
) (
    input  logic            clock,
    input  logic            reset,
    md_issue_ctrl_if.master bus
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    md_state_e       state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic            is_div_q, is_div_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     res_ir_q, res_ir_d;
    logic [31:0]     res_val_q, res_val_d;

    logic        detect;
    logic        timeout;
    logic [16:0] exc_code;

    assign detect   = is_md_op(bus.ir_x);
    assign timeout  = (cnt_q == CntMax);
    assign exc_code = is_div_q ? 17'(RSTATUS_DIV) : 17'(RSTATUS_MUL);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        cnt_d     = cnt_q;
        // Result registers are only loaded on entry to DONE, so they read as
        // zero in every other state.
        res_ir_d  = '0;
        res_val_d = '0;

        unique case (state_q)
            StIdle: begin
                if (detect) begin
                    state_d  = StStart;
                    ir_d     = bus.ir_x;
                    a_d      = bus.operand_a;
                    b_d      = bus.operand_b;
                    is_div_d = (bus.ir_x[6:2] == ALU_DIV);
                end
            end
            StStart: begin
                // md_ready is deliberately ignored here.
                state_d = StBusy;
                cnt_d   = '0;
            end
            StBusy: begin
                if (bus.md_ready) begin
                    // Ready beats a coincident timeout.
                    state_d = StDone;
                    if (bus.md_exception) begin
                        res_ir_d  = rstatus_ir(exc_code);
                        res_val_d = 32'(exc_code);
                    end else begin
                        res_ir_d  = ir_q;
                        res_val_d = bus.md_result;
                    end
                end else if (timeout) begin
                    state_d   = StDone;
                    res_ir_d  = rstatus_ir(exc_code);
                    res_val_d = 32'(exc_code);
                end
                if (!timeout) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            cnt_q     <= '0;
            res_ir_q  <= '0;
            res_val_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            cnt_q     <= cnt_d;
            res_ir_q  <= res_ir_d;
            res_val_q <= res_val_d;
        end
    end

    assign bus.md_ctrl_mult = (state_q == StStart) && !is_div_q;
    assign bus.md_ctrl_div  = (state_q == StStart) && is_div_q;
    assign bus.md_a         = a_q;
    assign bus.md_b         = b_q;
    // Stall drops in DONE so D/X advances while X/M takes the override.
    assign bus.stall        = reset && (((state_q == StIdle) && detect) ||
                                        (state_q == StStart) || (state_q == StBusy));
    assign bus.busy         = (state_q != StIdle);
    assign bus.out_valid    = (state_q == StDone);
    assign bus.out_ir       = res_ir_q;
    assign bus.out_value    = res_val_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl
// Directed bench for md_issue_ctrl. A cycle-level reference model tracks each
// operation by its age since detection and checks every output each cycle;
// the directed sequences additionally pin latencies and results to
// hand-computed constants.
module tb_md_issue_ctrl;
    import md_issue_ctrl_pkg::*;

    localparam int unsigned TIMEOUT = 40;
    // mul $3,$1,$2 and div $4,$5,$6 (R-type, alu op in [6:2])
    localparam logic [31:0] MUL_IR  = 32'h00C2_2018;
    localparam logic [31:0] DIV_IR  = 32'h010A_601C;

    logic clock = 1'b0;
    logic reset;

    md_issue_ctrl_if bus_if ();

    md_issue_ctrl #(
        .TIMEOUT    (TIMEOUT),
        .RSTATUS_MUL(4),
        .RSTATUS_DIV(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Statistics gathered from DUT outputs, cleared per directed test.
    int          stall_cnt, valid_cnt, mult_cnt, div_cnt;
    int          first_valid_cyc, last_valid_cyc, last_mult_cyc;
    logic [31:0] last_vir, last_vval;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_stats();
        stall_cnt       = 0;
        valid_cnt       = 0;
        mult_cnt        = 0;
        div_cnt         = 0;
        first_valid_cyc = -1;
        last_valid_cyc  = -1;
        last_mult_cyc   = -1;
        last_vir        = '0;
        last_vval       = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    // ---------------- reference model ----------------
    bit          m_active, m_in_done, m_div;
    int          m_age;
    logic [31:0] m_ir, m_a, m_b, m_res_ir, m_res_val;

    function automatic bit m_detect(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && (ir != 32'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
    endfunction

    function automatic logic [31:0] m_status_ir(input int code);
        return (32'd5 << 27) | (32'd30 << 22) | 32'(code);
    endfunction

    always @(negedge clock) begin
        logic        e_stall, e_busy, e_valid, e_mult, e_div;
        logic [31:0] e_a, e_b, e_ir, e_val;
        int          code;
        cyc++;
        e_stall = 0; e_busy = 0; e_valid = 0; e_mult = 0; e_div = 0;
        e_ir = '0; e_val = '0;
        if (!reset) begin
            m_active  = 0;
            m_in_done = 0;
            m_a       = '0;
            m_b       = '0;
            e_a       = '0;
            e_b       = '0;
        end else begin
            e_a = m_a;
            e_b = m_b;
            if (m_in_done) begin
                e_busy    = 1;
                e_valid   = 1;
                e_ir      = m_res_ir;
                e_val     = m_res_val;
                m_in_done = 0;
                m_active  = 0;
            end else if (m_active) begin
                e_busy  = 1;
                e_stall = 1;
                code    = m_div ? 5 : 4;
                if (m_age == 1) begin
                    e_mult = !m_div;
                    e_div  = m_div;
                end else if (bus_if.md_ready) begin
                    m_in_done = 1;
                    if (bus_if.md_exception) begin
                        m_res_ir  = m_status_ir(code);
                        m_res_val = 32'(code);
                    end else begin
                        m_res_ir  = m_ir;
                        m_res_val = bus_if.md_result;
                    end
                end else if (m_age - 2 == int'(TIMEOUT)) begin
                    m_in_done = 1;
                    m_res_ir  = m_status_ir(code);
                    m_res_val = 32'(code);
                end
                m_age++;
            end else if (m_detect(bus_if.ir_x)) begin
                e_stall  = 1;
                m_active = 1;
                m_age    = 1;
                m_ir     = bus_if.ir_x;
                m_div    = (bus_if.ir_x[6:2] == 5'd7);
                m_a      = bus_if.operand_a;
                m_b      = bus_if.operand_b;
            end
        end

        check($sformatf("stall@%0d", cyc),     32'(bus_if.stall),        32'(e_stall));
        check($sformatf("busy@%0d", cyc),      32'(bus_if.busy),         32'(e_busy));
        check($sformatf("out_valid@%0d", cyc), 32'(bus_if.out_valid),    32'(e_valid));
        check($sformatf("ctrl_mult@%0d", cyc), 32'(bus_if.md_ctrl_mult), 32'(e_mult));
        check($sformatf("ctrl_div@%0d", cyc),  32'(bus_if.md_ctrl_div),  32'(e_div));
        check($sformatf("md_a@%0d", cyc),      bus_if.md_a,              e_a);
        check($sformatf("md_b@%0d", cyc),      bus_if.md_b,              e_b);
        check($sformatf("out_ir@%0d", cyc),    bus_if.out_ir,            e_ir);
        check($sformatf("out_value@%0d", cyc), bus_if.out_value,         e_val);

        if (bus_if.stall === 1'b1) stall_cnt++;
        if (bus_if.md_ctrl_mult === 1'b1) begin
            mult_cnt++;
            last_mult_cyc = cyc;
        end
        if (bus_if.md_ctrl_div === 1'b1) div_cnt++;
        if (bus_if.out_valid === 1'b1) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
            last_vir       = bus_if.out_ir;
            last_vval      = bus_if.out_value;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int  k;
        bit  got;
        clear_stats();
        reset               = 1'b0;
        bus_if.ir_x         = '0;
        bus_if.operand_a    = '0;
        bus_if.operand_b    = '0;
        bus_if.md_result    = '0;
        bus_if.md_exception = 1'b0;
        bus_if.md_ready     = 1'b0;

        // Reset state, including stall forced low with a mul presented.
        bus_if.ir_x = MUL_IR;
        tick_n(3);
        check("reset_stall", 32'(bus_if.stall), 32'd0);
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_md_a", bus_if.md_a, 32'd0);
        bus_if.ir_x = '0;
        reset = 1'b1;
        tick();

        // Non-mul/div words must not be detected.
        clear_stats();
        bus_if.ir_x = 32'h2800_0018;  // addi-opcode word with 00110 in [6:2]
        tick();
        bus_if.ir_x = 32'h00C2_2000;  // R-type, alu op 0
        tick();
        bus_if.ir_x = '0;
        tick();
        check("no_detect_stall", 32'(stall_cnt), 32'd0);

        // 1: mul, ready 17 cycles after the ctrl pulse.
        clear_stats();
        bus_if.ir_x = MUL_IR;
        bus_if.operand_a = 32'd10;
        bus_if.operand_b = 32'd20;
        tick_n(18);
        check("t1_md_a_busy", bus_if.md_a, 32'd10);
        check("t1_md_b_busy", bus_if.md_b, 32'd20);
        bus_if.md_ready  = 1'b1;
        bus_if.md_result = 32'h0000_00C8;
        tick();
        bus_if.md_ready  = 1'b0;
        bus_if.md_result = '0;
        tick();
        bus_if.ir_x = '0;
        tick();
        check("t1_stall_len", 32'(stall_cnt), 32'd19);
        check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
        check("t1_out_ir", last_vir, MUL_IR);
        check("t1_out_value", last_vval, 32'h0000_00C8);
        check("t1_pulse_to_done", 32'(last_valid_cyc - last_mult_cyc), 32'd18);

        // 2: div with exception.
        clear_stats();
        bus_if.ir_x = DIV_IR;
        bus_if.operand_a = 32'd7;
        bus_if.operand_b = 32'd0;
        tick_n(5);
        bus_if.md_ready     = 1'b1;
        bus_if.md_exception = 1'b1;
        bus_if.md_result    = 32'hDEAD_BEEF;
        tick();
        bus_if.md_ready     = 1'b0;
        bus_if.md_exception = 1'b0;
        tick();
        bus_if.ir_x = '0;
        tick();
        check("t2_out_ir", last_vir, 32'h2F80_0005);
        check("t2_out_value", last_vval, 32'd5);
        check("t2_div_pulses", 32'(div_cnt), 32'd1);
        check("t2_mult_pulses", 32'(mult_cnt), 32'd0);

        // 3: mul timeout.
        clear_stats();
        bus_if.ir_x = MUL_IR;
        bus_if.operand_a = 32'd3;
        bus_if.operand_b = 32'd4;
        k   = 0;
        got = 0;
        while (k < 60 && !got) begin
            tick();
            k++;
            if (bus_if.out_valid === 1'b1) got = 1;
        end
        check("t3_done_seen", 32'(got), 32'd1);
        check("t3_latency", 32'(k), 32'd43);
        check("t3_counter_sat", 32'(dut.cnt_q), 32'd40);
        tick();
        bus_if.ir_x = '0;
        tick();
        check("t3_out_ir", last_vir, 32'h2F80_0004);
        check("t3_out_value", last_vval, 32'd4);
        check("t3_stall_len", 32'(stall_cnt), 32'd43);

        // 4: back-to-back mul (instruction stays in X after DONE).
        clear_stats();
        bus_if.ir_x = MUL_IR;
        bus_if.operand_a = 32'd1;
        bus_if.operand_b = 32'd2;
        tick_n(2);
        bus_if.md_ready  = 1'b1;
        bus_if.md_result = 32'd11;
        tick();
        bus_if.md_ready  = 1'b0;
        tick();
        bus_if.operand_a = 32'd5;
        bus_if.operand_b = 32'd6;
        tick_n(2);
        check("t4_md_a_second", bus_if.md_a, 32'd5);
        bus_if.md_ready  = 1'b1;
        bus_if.md_result = 32'd22;
        tick();
        bus_if.md_ready  = 1'b0;
        tick();
        bus_if.ir_x = '0;
        tick();
        check("t4_mult_pulses", 32'(mult_cnt), 32'd2);
        check("t4_valid_cnt", 32'(valid_cnt), 32'd2);
        check("t4_done_to_start", 32'(last_mult_cyc - first_valid_cyc), 32'd2);
        check("t4_out_value", last_vval, 32'd22);
        check("t4_stall_len", 32'(stall_cnt), 32'd6);

        // 5: reset during BUSY, stale ready afterwards, then a fresh mul.
        clear_stats();
        bus_if.ir_x = MUL_IR;
        bus_if.operand_a = 32'd9;
        bus_if.operand_b = 32'd9;
        tick_n(4);
        reset = 1'b0;
        bus_if.ir_x = '0;
        #1;
        check("t5_reset_stall", 32'(bus_if.stall), 32'd0);
        check("t5_reset_busy", 32'(bus_if.busy), 32'd0);
        tick();
        reset = 1'b1;
        bus_if.md_ready  = 1'b1;
        bus_if.md_result = 32'h55;
        tick();
        bus_if.md_ready  = 1'b0;
        tick();
        check("t5_no_valid", 32'(valid_cnt), 32'd0);
        check("t5_idle_busy", 32'(bus_if.busy), 32'd0);
        clear_stats();
        bus_if.ir_x = MUL_IR;
        bus_if.operand_a = 32'd2;
        bus_if.operand_b = 32'd3;
        tick_n(3);
        bus_if.md_ready  = 1'b1;
        bus_if.md_result = 32'd6;
        tick();
        bus_if.md_ready  = 1'b0;
        tick();
        bus_if.ir_x = '0;
        tick();
        check("t5_fresh_valid", 32'(valid_cnt), 32'd1);
        check("t5_fresh_ir", last_vir, MUL_IR);
        check("t5_fresh_value", last_vval, 32'd6);

        // 6: ready during START is ignored; BUSY sample is used.
        clear_stats();
        bus_if.ir_x = MUL_IR;
        bus_if.operand_a = 32'd8;
        bus_if.operand_b = 32'd8;
        tick();
        bus_if.md_ready  = 1'b1;
        bus_if.md_result = 32'h111;
        tick();
        bus_if.md_ready  = 1'b0;
        tick();
        bus_if.md_ready  = 1'b1;
        bus_if.md_result = 32'h222;
        tick();
        bus_if.md_ready  = 1'b0;
        tick();
        bus_if.ir_x = '0;
        tick();
        check("t6_out_value", last_vval, 32'h222);
        check("t6_valid_cnt", 32'(valid_cnt), 32'd1);
        check("t6_pulse_to_done", 32'(last_valid_cyc - last_mult_cyc), 32'd3);

        tick_n(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
